// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The width helper sizes counters from their terminal values.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Bits needed to count up to value-1, never less than one.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, framing check.
// Exposes the completed byte a cycle early so the packer can act on the stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_valid,
    output logic                      frame_err,
    output logic                      busy,
    output logic                      byte_strobe,
    output logic [UART_DATA_BITS-1:0] byte_next,
    output logic                      start_det,
    output logic                      idle
);

    localparam int                BAUD_W    = clog2w(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync;
    logic                      rx_s;
    rx_state_e                 state, state_n;
    logic [BAUD_W-1:0]         baud_cnt, baud_n;
    logic [2:0]                bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      stop_wait, stop_wait_n;
    logic                      frame_n;

    assign rx_s      = sync[1];
    assign busy      = (state != IDLE);
    assign idle      = (state == IDLE);
    assign byte_next = shift;

    // Synchroniser resets high so a line released from reset is not a start bit.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            stop_wait  <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], uart_rx};
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            stop_wait  <= stop_wait_n;
            byte_valid <= byte_strobe;
            frame_err  <= frame_n;
            if (byte_strobe) begin
                byte_data <= shift;
            end
        end
    end

    always_comb begin
        state_n     = state;
        baud_n      = baud_cnt;
        bit_n       = bit_cnt;
        shift_n     = shift;
        stop_wait_n = stop_wait;
        frame_n     = 1'b0;
        byte_strobe = 1'b0;
        start_det   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n   = START;
                    baud_n    = '0;
                    bit_n     = '0;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_n  = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_n  = '0;
                    shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line is high again.
                if (stop_wait) begin
                    if (rx_s) begin
                        stop_wait_n = 1'b0;
                        state_n     = IDLE;
                    end
                end else if (baud_cnt == FULL_LAST) begin
                    baud_n = '0;
                    if (rx_s) begin
                        byte_strobe = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        frame_n     = 1'b1;
                        stop_wait_n = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs bytes LSB-first into a 32-bit word with valid/ready,
// a GPIO hold register, inter-byte timeout and overrun detection.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] gpio_word,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        overrun,
    output logic        busy
);

    localparam int            TO_TERM  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TO_W     = clog2w(TO_TERM + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TERM);
    localparam logic [1:0]    LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic              byte_strobe;
    logic [7:0]        byte_next;
    logic              start_det;
    logic              idle;
    logic [1:0]        idx;
    logic [31:0]       lanes;
    logic [31:0]       packed_word;
    logic [TO_W-1:0]   tcnt;
    logic              word_done;
    logic              accept;
    logic              to_fire;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .byte_strobe(byte_strobe),
        .byte_next  (byte_next),
        .start_det  (start_det),
        .idle       (idle)
    );

    always_comb begin
        packed_word = lanes;
        packed_word[{idx, 3'b000} +: 8] = byte_next;
        word_done = byte_strobe && (idx == LAST_IDX);
        accept    = word_valid && word_ready;
        to_fire   = idle && (idx != 2'd0) && !start_det && (tcnt == TO_LAST);
    end

    // Completion and acceptance in the same cycle keeps word_valid high with new data.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            lanes       <= '0;
            tcnt        <= '0;
            word_data   <= '0;
            gpio_word   <= '0;
            word_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            if (word_done) begin
                word_valid <= 1'b1;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
            if (byte_strobe) begin
                tcnt <= '0;
                if (word_done) begin
                    word_data <= packed_word;
                    gpio_word <= packed_word;
                    lanes     <= '0;
                    idx       <= '0;
                    overrun   <= word_valid && !word_ready;
                end else begin
                    lanes <= packed_word;
                    idx   <= idx + 2'd1;
                end
            end else if (start_det) begin
                tcnt <= '0;
            end else if (to_fire) begin
                idx         <= '0;
                lanes       <= '0;
                tcnt        <= '0;
                timeout_err <= 1'b1;
            end else if (idle && (idx != 2'd0)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed-plus-random bench for uart_word_rx at 16 clocks/bit, with a second
// single-byte-word instance at 868 clocks/bit; expectations come from a byte-packing model.
module tb_uart_word_rx;

    localparam int CLKS = 16;
    localparam int SLOW = 868;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        uart_rx_s;
    logic        word_ready;
    logic [7:0]  byte_data,  byte_data_s;
    logic        byte_valid, byte_valid_s;
    logic [31:0] word_data,  word_data_s;
    logic        word_valid, word_valid_s;
    logic [31:0] gpio_word,  gpio_word_s;
    logic        frame_err,  frame_err_s;
    logic        timeout_err, timeout_err_s;
    logic        overrun,    overrun_s;
    logic        busy,       busy_s;

    uart_word_rx #(.CLKS_PER_BIT(CLKS), .BYTES_PER_WORD(4), .TIMEOUT_BITS(20)) dut (
        .sys_clk(sys_clk), .rst(rst), .uart_rx(uart_rx),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .gpio_word(gpio_word), .frame_err(frame_err), .timeout_err(timeout_err),
        .overrun(overrun), .busy(busy)
    );

    uart_word_rx #(.CLKS_PER_BIT(SLOW), .BYTES_PER_WORD(1), .TIMEOUT_BITS(20)) dut_slow (
        .sys_clk(sys_clk), .rst(rst), .uart_rx(uart_rx_s),
        .byte_data(byte_data_s), .byte_valid(byte_valid_s),
        .word_data(word_data_s), .word_valid(word_valid_s), .word_ready(word_ready),
        .gpio_word(gpio_word_s), .frame_err(frame_err_s), .timeout_err(timeout_err_s),
        .overrun(overrun_s), .busy(busy_s)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    // Pulse and event counters, all sampled on the falling edge.
    int          byte_cnt = 0, frame_cnt = 0, timeout_cnt = 0, overrun_cnt = 0;
    int          acc_cnt = 0, wv_cycles = 0, wv_rise_bad = 0;
    int          busy_run = 0, busy_runs = 0, busy_last_run = 0;
    int          slow_bytes = 0, slow_errs = 0, slow_busy = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [31:0] last_acc_word = 32'h0;
    logic        wv_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (byte_valid) begin
            byte_cnt++;
            last_byte = byte_data;
        end
        if (frame_err)   frame_cnt++;
        if (timeout_err) timeout_cnt++;
        if (overrun)     overrun_cnt++;
        if (word_valid)  wv_cycles++;
        if (word_valid && word_ready) begin
            acc_cnt++;
            last_acc_word = word_data;
        end
        if (word_valid && !wv_prev && !byte_valid) wv_rise_bad++;
        wv_prev = word_valid;
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_runs++;
            busy_last_run = busy_run;
            busy_run = 0;
        end
        if (byte_valid_s) slow_bytes++;
        if (frame_err_s || timeout_err_s || overrun_s || word_valid_s === 1'bx) slow_errs++;
        if (busy_s) slow_busy++;
    end

    // Reference: a word is its bytes weighted by powers of 256, first byte lowest.
    function automatic logic [31:0] packWord(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        return 32'(b0) + 32'(b1) * 256 + 32'(b2) * 65536 + 32'(b3) * 16777216;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic driveBits(input logic v, input int nbits);
        uart_rx = v;
        waitCycles(nbits * CLKS);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit good_stop);
        driveBits(1'b0, 1);
        for (int i = 0; i < 8; i++) driveBits(data[i], 1);
        if (good_stop) begin
            driveBits(1'b1, 1);
        end else begin
            driveBits(1'b0, 2);
            driveBits(1'b1, 1);
        end
    endtask

    task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(b0, 1'b1);
        applyStimulus(b1, 1'b1);
        applyStimulus(b2, 1'b1);
        applyStimulus(b3, 1'b1);
    endtask

    task automatic sendSlow(input logic [7:0] data);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_s = frame[i];
            waitCycles(SLOW);
        end
    endtask

    initial begin
        int b0, a0, f0, t0, o0, w0, r0;
        logic [7:0] rb [4];
        logic [7:0] rs;

        rst = 1'b1;
        uart_rx = 1'b1;
        uart_rx_s = 1'b1;
        word_ready = 1'b1;
        waitCycles(3);
        checkOutput("reset_byte_data", 32'(byte_data), 32'h0);
        checkOutput("reset_word_data", word_data, 32'h0);
        checkOutput("reset_gpio_word", gpio_word, 32'h0);
        checkOutput("reset_flags", 32'({byte_valid, word_valid, frame_err, timeout_err, overrun, busy}), 32'h0);
        rst = 1'b0;
        waitCycles(4);

        $display("[TB] basic packing");
        b0 = byte_cnt; a0 = acc_cnt; w0 = wv_cycles;
        sendWord(8'h01, 8'h02, 8'h03, 8'h04);
        waitCycles(2 * CLKS);
        checkOutput("basic_byte_pulses", 32'(byte_cnt - b0), 32'd4);
        checkOutput("basic_accepts", 32'(acc_cnt - a0), 32'd1);
        checkOutput("basic_word", last_acc_word, packWord(8'h01, 8'h02, 8'h03, 8'h04));
        checkOutput("basic_gpio", gpio_word, 32'h04030201);
        checkOutput("basic_word_data_held", word_data, 32'h04030201);
        checkOutput("basic_valid_cycles", 32'(wv_cycles - w0), 32'd1);
        checkOutput("basic_valid_with_byte", 32'(wv_rise_bad), 32'd0);

        $display("[TB] glitch rejection");
        b0 = byte_cnt; f0 = frame_cnt; r0 = busy_runs;
        uart_rx = 1'b0;
        waitCycles(CLKS / 4);
        uart_rx = 1'b1;
        waitCycles(2 * CLKS);
        checkOutput("glitch_no_byte", 32'(byte_cnt - b0), 32'd0);
        checkOutput("glitch_no_frame_err", 32'(frame_cnt - f0), 32'd0);
        checkOutput("glitch_busy_runs", 32'(busy_runs - r0), 32'd1);
        checkOutput("glitch_busy_short", 32'(busy_last_run <= CLKS / 2), 32'd1);
        checkOutput("glitch_busy_low", 32'(busy), 32'd0);

        $display("[TB] framing error");
        b0 = byte_cnt; f0 = frame_cnt; a0 = acc_cnt;
        applyStimulus(8'h55, 1'b0);
        waitCycles(CLKS);
        checkOutput("frame_err_pulses", 32'(frame_cnt - f0), 32'd1);
        checkOutput("frame_byte_dropped", 32'(byte_cnt - b0), 32'd0);
        applyStimulus(8'hA5, 1'b1);
        waitCycles(2);
        checkOutput("frame_next_byte", 32'(last_byte), 32'hA5);
        for (int i = 1; i < 4; i++) rb[i] = 8'($urandom);
        applyStimulus(rb[1], 1'b1);
        applyStimulus(rb[2], 1'b1);
        applyStimulus(rb[3], 1'b1);
        waitCycles(CLKS);
        checkOutput("frame_idx_kept_word", last_acc_word, packWord(8'hA5, rb[1], rb[2], rb[3]));
        checkOutput("frame_accepts", 32'(acc_cnt - a0), 32'd1);

        $display("[TB] timeout");
        t0 = timeout_cnt; a0 = acc_cnt;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        driveBits(1'b1, 25);
        checkOutput("timeout_pulses", 32'(timeout_cnt - t0), 32'd1);
        checkOutput("timeout_no_word", 32'(acc_cnt - a0), 32'd0);
        sendWord(8'h01, 8'h02, 8'h03, 8'h04);
        waitCycles(CLKS);
        checkOutput("timeout_clean_word", last_acc_word, packWord(8'h01, 8'h02, 8'h03, 8'h04));
        checkOutput("timeout_single", 32'(timeout_cnt - t0), 32'd1);

        $display("[TB] random words");
        for (int w = 0; w < 3; w++) begin
            a0 = acc_cnt;
            for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
            sendWord(rb[0], rb[1], rb[2], rb[3]);
            waitCycles(CLKS);
            checkOutput("random_accept", 32'(acc_cnt - a0), 32'd1);
            checkOutput("random_word", last_acc_word, packWord(rb[0], rb[1], rb[2], rb[3]));
        end

        $display("[TB] backpressure and overrun");
        word_ready = 1'b0;
        o0 = overrun_cnt; a0 = acc_cnt;
        sendWord(8'h01, 8'h02, 8'h03, 8'h04);
        waitCycles(CLKS);
        checkOutput("bp_valid_held", 32'(word_valid), 32'd1);
        checkOutput("bp_word_held", word_data, 32'h04030201);
        checkOutput("bp_no_overrun_yet", 32'(overrun_cnt - o0), 32'd0);
        sendWord(8'h05, 8'h06, 8'h07, 8'h08);
        waitCycles(CLKS);
        checkOutput("ovr_pulses", 32'(overrun_cnt - o0), 32'd1);
        checkOutput("ovr_word_data", word_data, packWord(8'h05, 8'h06, 8'h07, 8'h08));
        checkOutput("ovr_gpio", gpio_word, 32'h08070605);
        checkOutput("ovr_valid_high", 32'(word_valid), 32'd1);
        checkOutput("ovr_no_accept", 32'(acc_cnt - a0), 32'd0);
        word_ready = 1'b1;
        waitCycles(1);
        checkOutput("ready_clears_valid", 32'(word_valid), 32'd0);
        checkOutput("ready_accepted_word", last_acc_word, 32'h08070605);

        $display("[TB] mid-operation reset");
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        driveBits(1'b0, 1);
        for (int i = 0; i < 4; i++) driveBits(1'(i % 2), 1);
        uart_rx = 1'b1;
        repeat (CLKS / 2) @(posedge sys_clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_gpio_cleared", gpio_word, 32'h0);
        checkOutput("rst_word_cleared", word_data, 32'h0);
        checkOutput("rst_byte_cleared", 32'(byte_data), 32'h0);
        checkOutput("rst_busy_cleared", 32'(busy), 32'd0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2 * CLKS);
        a0 = acc_cnt;
        sendWord(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        waitCycles(CLKS);
        checkOutput("rst_fresh_accept", 32'(acc_cnt - a0), 32'd1);
        checkOutput("rst_fresh_word", last_acc_word, 32'hEFBEADDE);
        checkOutput("rst_fresh_gpio", gpio_word, 32'hEFBEADDE);

        $display("[TB] 868 clocks per bit, one byte per word");
        rs = 8'($urandom);
        b0 = slow_bytes;
        sendSlow(rs);
        waitCycles(8);
        checkOutput("slow_byte_pulses", 32'(slow_bytes - b0), 32'd1);
        checkOutput("slow_byte_data", 32'(byte_data_s), 32'(rs));
        checkOutput("slow_word_upper_zero", word_data_s, packWord(rs, 8'h00, 8'h00, 8'h00));
        checkOutput("slow_gpio", gpio_word_s, 32'(rs));
        checkOutput("slow_no_errors", 32'(slow_errs), 32'd0);
        checkOutput("slow_idle_after", 32'({busy_s, word_valid_s}), 32'd0);
        checkOutput("slow_busy_seen", 32'(slow_busy > 8 * SLOW), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
